// File: rtl/ball_motion.sv
// Ball position engine: steps the ball, reflects it off walls, paddle
// and block hits, and tracks lives through serve / move / lost / over.
module ball_motion #(
  parameter int R_BALL     = 8,
  parameter int H_BAR      = 8,
  parameter int W_BAR      = 64,
  parameter int Y_BAR      = 440,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480,
  parameter int TICK_DIV   = 250000,
  parameter int HOLD_TICKS = 64,
  parameter int LIVES      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] x_bar,
  input  logic       hit_u,
  input  logic       hit_d,
  input  logic       hit_l,
  input  logic       hit_r,
  output logic [9:0] x_ball,
  output logic [9:0] y_ball,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       moving,
  output logic       life_lost,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [1:0] S_SERVE = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_LOST  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [9:0] X_LO   = 10'(R_BALL);
  localparam logic [9:0] X_HI   = 10'(X_MAX - 1 - R_BALL);
  localparam logic [9:0] Y_LO   = 10'(R_BALL);
  localparam logic [9:0] Y_PAD  = 10'(Y_BAR - H_BAR - R_BALL);
  localparam logic [9:0] Y_LOST = 10'(Y_MAX - 1 - R_BALL);
  localparam logic [9:0] X_MID  = 10'(X_MAX / 2);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [10:0]   W_BAR_11  = 11'(W_BAR);

  logic [1:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic          dx;
  logic          dy;
  logic          tick;
  logic          dx_n;
  logic          dy_n;
  logic          on_pad;
  logic          set_r;
  logic          set_l;
  logic          set_d;
  logic          set_u;
  logic [9:0]    x_srv;
  logic [9:0]    x_step;
  logic [9:0]    y_step;
  logic [10:0]   xb11;
  logic [10:0]   xp11;

  assign tick      = (tick_cnt == TICK_LAST);
  assign moving    = (state == S_MOVE);
  assign game_over = (state == S_OVER);

  // Left paddle bound is tested as x_ball + W >= x_bar so it cannot wrap
  assign xb11   = {1'b0, x_ball};
  assign xp11   = {1'b0, x_bar};
  assign on_pad = (y_ball == Y_PAD)
               && (xb11 + W_BAR_11 >= xp11)
               && (xb11 <= xp11 + W_BAR_11);

  assign set_r = (x_ball <= X_LO) || hit_r;
  assign set_l = (x_ball >= X_HI) || hit_l;
  assign set_d = (y_ball <= Y_LO) || hit_d;
  assign set_u = hit_u || on_pad;

  always_comb begin
    dx_n = dx;
    unique case (1'b1)
      (set_r && !set_l): dx_n = 1'b1;
      (set_l && !set_r): dx_n = 1'b0;
      default:           dx_n = dx;
    endcase
  end

  always_comb begin
    dy_n = dy;
    unique case (1'b1)
      (set_d && !set_u): dy_n = 1'b1;
      (set_u && !set_d): dy_n = 1'b0;
      default:           dy_n = dy;
    endcase
  end

  always_comb begin
    x_srv = x_bar;
    unique case (1'b1)
      (x_bar < X_LO): x_srv = X_LO;
      (x_bar > X_HI): x_srv = X_HI;
      default:        x_srv = x_bar;
    endcase
  end

  assign x_step = dx_n ? x_ball + 10'd1 : x_ball - 10'd1;
  assign y_step = dy_n ? y_ball + 10'd1 : y_ball - 10'd1;

  always_comb begin
    next_x = x_ball;
    next_y = y_ball;
    if (moving) begin
      next_x = dx ? x_ball + 10'd1 : x_ball - 10'd1;
      next_y = dy ? y_ball + 10'd1 : y_ball - 10'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (state == S_SERVE && start) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_SERVE;
      x_ball    <= X_MID;
      y_ball    <= Y_PAD;
      dx        <= 1'b1;
      dy        <= 1'b0;
      lives     <= 2'(LIVES);
      hold_cnt  <= '0;
      life_lost <= 1'b0;
    end else begin
      life_lost <= 1'b0;
      unique case (state)
        S_SERVE: begin
          x_ball <= x_srv;
          y_ball <= Y_PAD;
          if (start) begin
            state <= S_MOVE;
            dx    <= 1'b1;
            dy    <= 1'b0;
          end
        end
        S_MOVE: begin
          dx <= dx_n;
          dy <= dy_n;
          // Falling past the bottom wins over any pending step
          if (y_ball >= Y_LOST) begin
            state     <= S_LOST;
            lives     <= lives - 2'd1;
            life_lost <= 1'b1;
          end else if (tick) begin
            x_ball <= x_step;
            y_ball <= y_step;
          end
        end
        S_LOST: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= (lives == 2'd0) ? S_OVER : S_SERVE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        S_OVER: begin
          state <= S_OVER;
        end
        default: begin
          state <= S_SERVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed serve/launch/hit steps, then random
// play against a behavioural model, game over and async reset.
module tb_ball_motion;

  localparam int TD = 4;
  localparam int HT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x_bar = 10'd100;
  logic       hit_u = 1'b0;
  logic       hit_d = 1'b0;
  logic       hit_l = 1'b0;
  logic       hit_r = 1'b0;
  logic [9:0] x_ball;
  logic [9:0] y_ball;
  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       moving;
  logic       life_lost;
  logic [1:0] lives;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  // model: ms 0 serve, 1 move, 2 lost, 3 over
  int ms, mx, my, mdx, mdy, ml, mtc, mhc, mpulse;

  ball_motion #(
    .TICK_DIV  (TD),
    .HOLD_TICKS(HT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x_bar    (x_bar),
    .hit_u    (hit_u),
    .hit_d    (hit_d),
    .hit_l    (hit_l),
    .hit_r    (hit_r),
    .x_ball   (x_ball),
    .y_ball   (y_ball),
    .next_x   (next_x),
    .next_y   (next_y),
    .moving   (moving),
    .life_lost(life_lost),
    .lives    (lives),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  function automatic int sgn(input int b);
    return (b != 0) ? 1 : -1;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mx = 320; my = 424; mdx = 1; mdy = 0;
    ml = 3; mtc = 0; mhc = 0; mpulse = 0;
  endtask

  task automatic model_step();
    int tick, ntc, ndx, ndy, xb;
    bit s1, s0, pad;
    if (!reset) begin
      model_reset();
      return;
    end
    xb = int'(x_bar);
    tick = (mtc == TD - 1);
    ntc = tick ? 0 : mtc + 1;
    mpulse = 0;
    case (ms)
      0: begin
        mx = clampi(xb, 8, 631);
        my = 424;
        if (start) begin
          ms = 1; mdx = 1; mdy = 0; ntc = 0;
        end
      end
      1: begin
        pad = (my == 424) && (mx >= xb - 64) && (mx <= xb + 64);
        ndx = mdx;
        s1 = (mx <= 8) || hit_r;
        s0 = (mx >= 631) || hit_l;
        if (s1 != s0) ndx = s1;
        ndy = mdy;
        s1 = (my <= 8) || hit_d;
        s0 = hit_u || pad;
        if (s1 != s0) ndy = s1;
        if (my >= 471) begin
          ms = 2; ml = ml - 1; mpulse = 1;
        end else if (tick) begin
          mx = mx + sgn(ndx);
          my = my + sgn(ndy);
        end
        mdx = ndx;
        mdy = ndy;
      end
      2: begin
        if (tick) begin
          if (mhc == HT - 1) begin
            mhc = 0;
            ms = (ml == 0) ? 3 : 0;
          end else begin
            mhc++;
          end
        end
      end
      default: ;
    endcase
    mtc = ntc;
  endtask

  task automatic check_all();
    chk("x_ball", x_ball, mx);
    chk("y_ball", y_ball, my);
    chk("next_x", next_x, (ms == 1) ? mx + sgn(mdx) : mx);
    chk("next_y", next_y, (ms == 1) ? my + sgn(mdy) : my);
    chk("moving", moving, ms == 1);
    chk("life_lost", life_lost, mpulse);
    chk("lives", lives, ml);
    chk("game_over", game_over, ms == 3);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    int track;
    int n;
    bit keep_dx;
    model_reset();
    track = 0;
    repeat (2) @(negedge clock);
    chk("rst_x", x_ball, 320);
    chk("rst_y", y_ball, 424);
    chk("rst_lives", lives, 3);
    chk("rst_moving", moving, 0);
    chk("rst_over", game_over, 0);
    chk("rst_lost", life_lost, 0);

    reset = 1'b1;
    x_bar = 10'd100;
    cycle();
    chk("serve_x", x_ball, 100);
    chk("serve_nx", next_x, 100);
    x_bar = 10'd2;
    cycle();
    chk("serve_clamp", x_ball, 8);

    x_bar = 10'd320;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("launch_mv", moving, 1);
    repeat (4) cycle();
    chk("step_x", x_ball, 321);
    chk("step_y", y_ball, 423);
    chk("step_nx", next_x, 322);
    chk("step_ny", next_y, 422);

    hit_d = 1'b1;
    cycle();
    hit_d = 1'b0;
    chk("hit_d", next_y, int'(y_ball) + 1);
    hit_u = 1'b1;
    cycle();
    hit_u = 1'b0;
    chk("hit_u", next_y, int'(y_ball) - 1);
    keep_dx = (next_x > x_ball);
    hit_l = 1'b1;
    hit_r = 1'b1;
    cycle();
    hit_l = 1'b0;
    hit_r = 1'b0;
    chk("hit_lr", next_x > x_ball, keep_dx);

    for (int c = 0; c < 40000 && bad < 50; c++) begin
      if (c == 20000) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_x", x_ball, 320);
        chk("mid_rst_lives", lives, 3);
        chk("mid_rst_mv", moving, 0);
        @(negedge clock);
        check_all();
        reset = 1'b1;
      end
      hit_u = ($urandom_range(0, 39) == 0);
      hit_d = ($urandom_range(0, 39) == 0);
      hit_l = ($urandom_range(0, 39) == 0);
      hit_r = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 7) == 0);
      if (c % 2000 == 0) track = $urandom_range(0, 1);
      if (c % 50 == 0) begin
        if (track != 0)
          x_bar = 10'(clampi(mx + $urandom_range(0, 140) - 70, 0, 700));
        else
          x_bar = 10'($urandom_range(0, 639));
      end
      cycle();
    end

    hit_u = 1'b0; hit_d = 1'b0; hit_l = 1'b0; hit_r = 1'b0;
    start = 1'b0;
    #2 reset = 1'b0;
    @(negedge clock);
    model_reset();
    check_all();
    reset = 1'b1;
    x_bar = 10'd1000;
    start = 1'b1;
    n = 0;
    while (ms != 3 && n < 30000 && bad < 50) begin
      cycle();
      n++;
    end
    chk("over_reached", game_over, 1);
    chk("over_lives", lives, 0);
    repeat (20) cycle();
    chk("over_start_ign", moving, 0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("async_rst_lives", lives, 3);
    chk("async_rst_over", game_over, 0);
    chk("async_rst_y", y_ball, 424);
    @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    x_bar = 10'd200;
    cycle();
    chk("post_rst_x", x_ball, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
